// File: rtl/grant_decode_arbiter.sv
// grant_decode_arbiter: round-robin 16-way arbiter with hold limit, driving an index and matching one-hot grant
module grant_decode_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        gnt_valid,
    output logic        timeout
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    localparam logic [7:0] hold_max = 8'(MAX_HOLD);
    state_t      state, state_nx;
    logic [3:0]  ptr, ptr_nx, gnt_idx_nx, pick;
    logic [7:0]  hold_cnt, hold_cnt_nx;
    logic [15:0] gnt_nx;
    logic        gnt_valid_nx, timeout_nx, found;

    // rotating priority search starting just after the last served requester
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!found && req[4'(ptr + 4'(i + 1))]) begin
                pick  = 4'(ptr + 4'(i + 1));
                found = 1'b1;
            end
        end
    end

    // next state and next registered outputs; a drop on the limit cycle counts as a normal release
    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        hold_cnt_nx  = hold_cnt;
        gnt_nx       = gnt;
        gnt_idx_nx   = gnt_idx;
        gnt_valid_nx = gnt_valid;
        timeout_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nx     = GRANT;
                    gnt_idx_nx   = pick;
                    gnt_nx       = 16'd1 << pick;
                    gnt_valid_nx = 1'b1;
                    hold_cnt_nx  = 8'd1;
                end
            end
            GRANT: begin
                if (!req[gnt_idx] || (hold_max != 8'd0 && hold_cnt == hold_max)) begin
                    state_nx     = GAP;
                    ptr_nx       = gnt_idx;
                    gnt_nx       = '0;
                    gnt_idx_nx   = '0;
                    gnt_valid_nx = 1'b0;
                    timeout_nx   = req[gnt_idx];
                end else begin
                    hold_cnt_nx = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state and output registers; reset clears outputs without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 4'd15;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            hold_cnt  <= hold_cnt_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= gnt_idx_nx;
            gnt_valid <= gnt_valid_nx;
            timeout   <= timeout_nx;
        end
    end
endmodule
